clock_rate_monitor: RTL and testbench
=====================================

CLOCK_RATE_MONITOR -- requirements
Module: clock_rate_monitor

Interface
REQ-001 Parameter EXPECT_HALF, default 2: expected half-period of the monitored clock, in clock100 cycles (2 = 25 MHz at 50% duty).
REQ-002 Parameter LOCK_COUNT, default 4: consecutive good half-periods required to lock.
REQ-003 Parameter TIMEOUT, default 16: cycles without an edge that count as stuck; legal only if TIMEOUT > 2*EXPECT_HALF and TIMEOUT <= 255.
REQ-004 clock100  input  1  sole clock; all state on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 clk_in  input  1  divided clock, sampled as data.
REQ-007 clear  input  1  synchronous fault clear / restart.
REQ-008 rise_tick  output  1  one-cycle pulse per detected clk_in rising edge.
REQ-009 fall_tick  output  1  one-cycle pulse per detected clk_in falling edge.
REQ-010 locked  output  1  high while in LOCKED.
REQ-011 fault  output  1  high while in FAULT.
REQ-012 fault_code  output  2  00 none, 01 short, 10 long, 11 stuck.
REQ-013 half_period  output  8  last captured half-period length.

Function
REQ-014 clk_in SHALL pass through two flops, s1 then s2; edge = s1 != s2; rise = s1 & ~s2; fall = ~s1 & s2.
REQ-015 rise_tick/fall_tick SHALL be decoded from s1/s2 only, with no other logic in the path, and SHALL assert the cycle after the clock100 edge that first samples the new clk_in level.
REQ-016 Counter cnt[7:0] SHALL increment each cycle without an edge and saturate at 255; on an edge cycle capture = cnt+1 and cnt SHALL clear to 0.
REQ-017 half_period SHALL load the capture on every edge, including in IDLE.
REQ-018 Timeout SHALL be the condition: no edge and cnt == TIMEOUT-1. An edge in the same cycle SHALL win over timeout.
REQ-019 FSM states: IDLE, ACQUIRE, LOCKED, FAULT.
REQ-020 IDLE: on first edge go to ACQUIRE with good_cnt=0. The capture SHALL NOT be judged.
REQ-021 ACQUIRE, on edge:
- if capture == EXPECT_HALF, increment good_cnt and go to LOCKED when it reaches LOCK_COUNT;
- otherwise set good_cnt=0 and stay in ACQUIRE.
REQ-022 ACQUIRE: timeout SHALL return to IDLE. No fault SHALL be raised in ACQUIRE.
REQ-023 LOCKED, on edge:
- capture < EXPECT_HALF: go to FAULT with code 01;
- capture > EXPECT_HALF: go to FAULT with code 10;
- timeout: go to FAULT with code 11.
REQ-024 FAULT SHALL hold fault_code and remain until clear.
REQ-025 clear SHALL have priority in every state: next state IDLE, good_cnt=0, fault_code=00. cnt and half_period SHALL be unaffected.
REQ-026 locked, fault and fault_code SHALL change in the cycle following the deciding edge or timeout. fault_code SHALL be 00 outside FAULT.
REQ-027 A false edge after reset, caused by clk_in already high, SHALL be absorbed by the IDLE discard rule.

Reset
REQ-028 reset_n low SHALL immediately set:
- s1, s2, cnt, good_cnt and half_period to 0;
- state to IDLE;
- all outputs to 0.
REQ-029 Reset asserted mid-operation SHALL abort any lock or fault. Re-acquisition after release SHALL follow REQ-020 to REQ-021.

Structure
REQ-030 Shared package snake_clk_pkg SHALL hold the state enum and the fault_code constants (FC_NONE, FC_SHORT, FC_LONG, FC_STUCK).
REQ-031 Sub-module edge_sync SHALL hold the s1/s2 flops and the rise/fall/edge decode. Counter and FSM SHALL live in clock_rate_monitor.

Verification
REQ-032 clk_in /4 pattern (2 high, 2 low) after reset release: rise_tick every 4 cycles, half_period=2, locked=1 after the first edge plus 4 good edges.
REQ-033 While locked, one high phase stretched to 3 cycles: fault=1, fault_code=10, half_period=3, locked=0 in the same cycle.
REQ-034 While locked, one phase of 1 cycle: fault_code=01.
REQ-035 While locked, clk_in held low: fault_code=11 exactly 16 cycles after the last edge. A variant with an edge on the 16th cycle: stays locked.
REQ-036 clear pulse in FAULT: IDLE and fault=0 next cycle; locked again after 1+4 good edges.
REQ-037 reset_n asserted mid-LOCKED between clock edges: all outputs 0 without waiting for clock100.

Source files
------------

// File: rtl/snake_clk_pkg.sv
// rtl/snake_clk_pkg.sv - shared state encoding and fault codes for the clock rate monitor
package snake_clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_SHORT = 2'b01;
  localparam logic [1:0] FC_LONG  = 2'b10;
  localparam logic [1:0] FC_STUCK = 2'b11;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

  // capture is cnt+1 and can reach 256 once cnt has saturated; clamp it for the 8-bit report
  function automatic logic [7:0] sat_capture(input logic [8:0] v);
    return v[8] ? CNT_MAX : v[7:0];
  endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer for the monitored clock with rise/fall/edge decode
module edge_sync (
  input  logic clock100,
  input  logic reset_n,
  input  logic data_i,
  output logic rise_o,
  output logic fall_o,
  output logic edge_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= data_i;
      s2_q <= s1_q;
    end
  end

  // Ticks come straight off the flops so they are glitch-free and one cycle wide.
  assign rise_o = s1_q & ~s2_q;
  assign fall_o = ~s1_q & s2_q;
  assign edge_o = s1_q ^ s2_q;

endmodule

// File: rtl/clock_rate_monitor.sv
// rtl/clock_rate_monitor.sv - measures half-periods of a divided clock and locks or faults on them
module clock_rate_monitor
  import snake_clk_pkg::*;
#(
  parameter int EXPECT_HALF = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic       clock100,
  input  logic       reset_n,
  input  logic       clk_in,
  input  logic       clear,
  output logic       rise_tick,
  output logic       fall_tick,
  output logic       locked,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] half_period
);

  localparam int              GOOD_W       = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [7:0]      TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [8:0]      EXPECT_CAP   = 9'(EXPECT_HALF);
  localparam logic [GOOD_W-1:0] LOCK_TARGET = GOOD_W'(LOCK_COUNT);

  logic              edge_det;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        hp_q, hp_d;
  logic [8:0]        capture;
  logic              timeout;
  state_e            state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [GOOD_W-1:0] good_inc;
  logic [1:0]        fc_q, fc_d;

  edge_sync u_edge_sync (
    .clock100 (clock100),
    .reset_n  (reset_n),
    .data_i   (clk_in),
    .rise_o   (rise_tick),
    .fall_o   (fall_tick),
    .edge_o   (edge_det)
  );

  assign capture  = {1'b0, cnt_q} + 9'd1;
  assign timeout  = !edge_det && (cnt_q == TIMEOUT_LAST);
  assign good_inc = good_q + GOOD_W'(1);

  always_comb begin
    cnt_d = sat_inc8(cnt_q);
    hp_d  = hp_q;
    if (edge_det) begin
      cnt_d = 8'd0;
      hp_d  = sat_capture(capture);
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    fc_d    = fc_q;
    if (clear) begin
      state_d = ST_IDLE;
      good_d  = '0;
      fc_d    = FC_NONE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // The first edge only starts a measurement; its capture spans an unknown interval.
          if (edge_det) begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end
        end
        ST_ACQUIRE: begin
          if (edge_det) begin
            if (capture == EXPECT_CAP) begin
              good_d = good_inc;
              if (good_inc == LOCK_TARGET) state_d = ST_LOCKED;
            end else begin
              good_d = '0;
            end
          end else if (timeout) begin
            state_d = ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (edge_det) begin
            if (capture < EXPECT_CAP) begin
              state_d = ST_FAULT;
              fc_d    = FC_SHORT;
            end else if (capture > EXPECT_CAP) begin
              state_d = ST_FAULT;
              fc_d    = FC_LONG;
            end
          end else if (timeout) begin
            state_d = ST_FAULT;
            fc_d    = FC_STUCK;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
      endcase
    end
  end

  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= 8'd0;
      hp_q    <= 8'd0;
      state_q <= ST_IDLE;
      good_q  <= '0;
      fc_q    <= FC_NONE;
    end else begin
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      state_q <= state_d;
      good_q  <= good_d;
      fc_q    <= fc_d;
    end
  end

  assign locked      = (state_q == ST_LOCKED);
  assign fault       = (state_q == ST_FAULT);
  assign fault_code  = fc_q;
  assign half_period = hp_q;

endmodule

// File: tb/tb_clock_rate_monitor.sv
// tb/tb_clock_rate_monitor.sv - directed and random checks of clock_rate_monitor against a timing model
module tb_clock_rate_monitor;

  localparam int EH = 2;
  localparam int LC = 4;
  localparam int TO = 16;

  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCKED = 2, M_FAULT = 3;

  logic       clock100 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       clk_in   = 1'b0;
  logic       clear    = 1'b0;
  logic       rise_tick, fall_tick, locked, fault;
  logic [1:0] fault_code;
  logic [7:0] half_period;

  int nvec = 0;
  int nerr = 0;

  // Model: time-based, cnt is elapsed cycles since the cycle index 'base'.
  int         cyc  = 0;
  int         base = 0;
  int         st   = M_IDLE;
  int         good = 0;
  logic [1:0] m_fc = 2'b00;
  logic [7:0] m_hp = 8'd0;
  logic       samp[$];

  clock_rate_monitor #(
    .EXPECT_HALF (EH),
    .LOCK_COUNT  (LC),
    .TIMEOUT     (TO)
  ) dut (
    .clock100    (clock100),
    .reset_n     (reset_n),
    .clk_in      (clk_in),
    .clear       (clear),
    .rise_tick   (rise_tick),
    .fall_tick   (fall_tick),
    .locked      (locked),
    .fault       (fault),
    .fault_code  (fault_code),
    .half_period (half_period)
  );

  always #5 clock100 = ~clock100;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] dut_out();
    return {rise_tick, fall_tick, locked, fault, fault_code, half_period};
  endfunction

  function automatic logic [13:0] model_out();
    logic a, b;
    a = samp[samp.size()-1];
    b = samp[samp.size()-2];
    return {a & ~b, ~a & b, st == M_LOCKED, st == M_FAULT, m_fc, m_hp};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    samp.delete();
    samp.push_back(1'b0);
    samp.push_back(1'b0);
    st   = M_IDLE;
    good = 0;
    m_fc = 2'b00;
    m_hp = 8'd0;
    base = cyc;
  endtask

  task automatic model_clock(input logic v, input logic c);
    int  el, cntv, cap;
    logic e, to_hit;
    el     = cyc - base;
    cntv   = (el > 255) ? 255 : el;
    cap    = cntv + 1;
    e      = samp[samp.size()-1] != samp[samp.size()-2];
    to_hit = !e && (cntv == TO - 1);
    if (c) begin
      st = M_IDLE; good = 0; m_fc = 2'b00;
    end else begin
      case (st)
        M_IDLE:   if (e) begin st = M_ACQ; good = 0; end
        M_ACQ: begin
          if (e) begin
            if (cap == EH) begin
              good++;
              if (good == LC) st = M_LOCKED;
            end else good = 0;
          end else if (to_hit) st = M_IDLE;
        end
        M_LOCKED: begin
          if (e) begin
            if (cap < EH) begin st = M_FAULT; m_fc = 2'b01; end
            else if (cap > EH) begin st = M_FAULT; m_fc = 2'b10; end
          end else if (to_hit) begin st = M_FAULT; m_fc = 2'b11; end
        end
        default: ;
      endcase
    end
    if (e) begin
      m_hp = (cap > 255) ? 8'd255 : 8'(cap);
      base = cyc + 1;
    end
    samp.push_back(v);
    if (samp.size() > 4) void'(samp.pop_front());
    cyc++;
  endtask

  // Drive for one clock100 cycle, advance the model, then compare at the falling edge.
  task automatic step(input logic v, input logic c);
    clk_in = v;
    clear  = c;
    @(posedge clock100);
    if (!reset_n) begin
      cyc++;
      model_reset();
    end else begin
      model_clock(v, c);
    end
    @(negedge clock100);
    check("cycle", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic phase(input logic v, input int len);
    for (int k = 0; k < len; k++) step(v, 1'b0);
  endtask

  task automatic pattern(input logic first, input int n);
    logic lvl;
    lvl = first;
    for (int p = 0; p < n; p++) begin
      phase(lvl, 2);
      lvl = ~lvl;
    end
  endtask

  initial begin
    logic lvl;
    int   len;
    model_reset();
    repeat (3) step(1'b0, 1'b0);
    check("reset_zero", 32'(dut_out()), 32'd0);
    reset_n = 1'b1;

    pattern(1'b1, 8);
    check("lock_div4", {locked, half_period}, {1'b1, 8'd2});

    phase(1'b1, 3);
    phase(1'b0, 2);
    check("long_fault", {locked, fault, fault_code, half_period}, {1'b0, 1'b1, 2'b10, 8'd3});
    phase(1'b1, 2);
    check("fault_hold", {fault, fault_code}, {1'b1, 2'b10});

    step(1'b0, 1'b1);
    check("clear_exit", {locked, fault, fault_code}, 4'b0000);
    pattern(1'b1, 8);
    check("relock_after_clear", {locked, fault}, 2'b10);

    phase(1'b1, 1);
    phase(1'b0, 2);
    check("short_fault", {fault, fault_code}, {1'b1, 2'b01});

    step(1'b0, 1'b1);
    pattern(1'b1, 8);
    check("lock_before_stuck", locked, 1'b1);
    phase(1'b0, 15);
    check("no_stuck_at_15", {locked, fault}, 2'b10);
    step(1'b0, 1'b0);
    check("stuck_at_16", {locked, fault, fault_code}, {1'b0, 1'b1, 2'b11});

    step(1'b0, 1'b1);
    pattern(1'b1, 8);
    phase(1'b0, 14);
    step(1'b1, 1'b0);
    check("edge_on_16_locked", {locked, fault}, 2'b10);
    step(1'b1, 1'b0);
    check("edge_beats_timeout", {fault, fault_code, half_period}, {1'b1, 2'b10, 8'd16});

    step(1'b0, 1'b1);
    lvl = 1'b1;
    repeat (80) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: len = 2;
        6, 7:             len = $urandom_range(1, 3);
        default:          len = $urandom_range(4, 20);
      endcase
      for (int k = 0; k < len; k++) step(lvl, $urandom_range(0, 39) == 0);
      lvl = ~lvl;
    end

    step(clk_in, 1'b1);
    pattern(~clk_in, 8);
    check("lock_before_reset", locked, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 32'(dut_out()), 32'd0);
    model_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    reset_n = 1'b1;
    step(1'b1, 1'b0);
    pattern(1'b0, 8);
    check("relock_after_false_edge", {locked, fault}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
